spmv_mem_model: RTL and testbench

Parametrised, synthesizable-style main-memory response model for spmv_pe benches. It replaces the fixed 1000-stage inline latency shift register with a configurable-latency, tagged, credit-controlled memory that honours back-pressure from the PE rather than aborting the simulation. It sits between the PE's req_mem_*/rsp_mem_* ports and a word-addressed backing array `mem[0:DEPTH-1]`, which benches preload hierarchically with $readmemh.

---
 rtl/spmv_mem_model.sv | 210 +++++++++++++++++++++
 tb/tb_spmv_mem_model.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : spmv_mem_model
// Brief    : Main-memory response model for spmv_pe. Loads have a configurable
//            latency and a tag, credits limit how many are outstanding, and
//            responses honour rsp_stall back-pressure. Optional random request
//            stall injection is enabled with SPMV_MEM_STALL_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spmv_mem_model #(
  parameter int LATENCY   = 16,
  parameter int DEPTH     = 65536,
  parameter int RSP_DEPTH = 32,
  parameter int ADDR_W    = 48,
  parameter int TAG_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_d_or_tag,
  output logic              req_stall,
  output logic              rsp_push,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [63:0]       rsp_q,
  input  logic              rsp_stall,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count,
  output logic              err
);

  localparam int IDX_W  = ADDR_W - 3;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam logic [IDX_W:0]   C_DEPTH_IDX = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_RSP_FULL  = CNT_W'(RSP_DEPTH);

  // Backing store; benches preload it hierarchically, reset leaves it alone.
  logic [63:0] mem [0:DEPTH-1];

  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              both_req;
  logic              ld_acc;
  logic              st_acc;
  logic              pop;
  logic              fifo_empty;
  logic              stall_inj;
  logic [63:0]       rd_data;
  logic              fifo_wr;
  logic [TAG_W-1:0]  fifo_wr_tag;
  logic [63:0]       fifo_wr_data;
  logic              unused_addr_lsb;

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              rsp_push_q, rsp_push_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic [31:0]       ld_count_q, ld_count_d;
  logic [31:0]       st_count_q, st_count_d;
  logic              err_q, err_d;

  logic [TAG_W-1:0]  fifo_tag  [RSP_DEPTH];
  logic [63:0]       fifo_data [RSP_DEPTH];

  assign unused_addr_lsb = ^req_addr[2:0];

  always_comb begin
    word_idx = req_addr[ADDR_W-1:3];
    mem_idx  = word_idx[MEM_AW-1:0];
    in_range = ({1'b0, word_idx} < C_DEPTH_IDX);
    both_req = req_ld & req_st;
    ld_acc   = req_ld & ~req_st & ~req_stall;
    st_acc   = req_st & ~req_ld & ~req_stall;
    rd_data  = in_range ? mem[mem_idx] : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (st_acc && in_range) begin
      mem[mem_idx] <= req_d_or_tag;
    end
  end

  // The accept edge itself counts as the first latency stage, so only
  // LATENCY-1 register stages sit between acceptance and the FIFO.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign fifo_wr      = ld_acc;
      assign fifo_wr_tag  = req_d_or_tag[TAG_W-1:0];
      assign fifo_wr_data = rd_data;
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic [STAGES-1:0] vld_q;
      logic [TAG_W-1:0]  tag_q  [STAGES];
      logic [63:0]       data_q [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= ld_acc;
          for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        tag_q[0]  <= req_d_or_tag[TAG_W-1:0];
        data_q[0] <= rd_data;
        for (int i = 1; i < STAGES; i++) begin
          tag_q[i]  <= tag_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end

      assign fifo_wr      = vld_q[STAGES-1];
      assign fifo_wr_tag  = tag_q[STAGES-1];
      assign fifo_wr_data = data_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_tag[wr_ptr_q[PTR_W-1:0]]  <= fifo_wr_tag;
      fifo_data[wr_ptr_q[PTR_W-1:0]] <= fifo_wr_data;
    end
  end

  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    pop           = ~fifo_empty & ~rsp_stall;
    wr_ptr_d      = wr_ptr_q + (PTR_W + 1)'(fifo_wr);
    rd_ptr_d      = rd_ptr_q + (PTR_W + 1)'(pop);
    outstanding_d = outstanding_q;
    if (ld_acc && !pop) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (pop && !ld_acc) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
    rsp_push_d = pop;
    rsp_tag_d  = rsp_tag_q;
    rsp_data_d = rsp_data_q;
    if (pop) begin
      rsp_tag_d  = fifo_tag[rd_ptr_q[PTR_W-1:0]];
      rsp_data_d = fifo_data[rd_ptr_q[PTR_W-1:0]];
    end
    ld_count_d = ld_count_q + (ld_acc ? 32'd1 : 32'd0);
    st_count_d = st_count_q + (st_acc ? 32'd1 : 32'd0);
    err_d      = err_q | both_req | ((ld_acc | st_acc) & ~in_range);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      rsp_push_q    <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_data_q    <= '0;
      ld_count_q    <= '0;
      st_count_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      rsp_push_q    <= rsp_push_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_data_q    <= rsp_data_d;
      ld_count_q    <= ld_count_d;
      st_count_q    <= st_count_d;
      err_q         <= err_d;
    end
  end

`ifdef SPMV_MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_inj = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_inj = 1'b0;
`endif

  assign req_stall = (outstanding_q == C_RSP_FULL) | stall_inj;
  assign rsp_push  = rsp_push_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_q     = rsp_data_q;
  assign ld_count  = ld_count_q;
  assign st_count  = st_count_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spmv_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_spmv_mem_model
// Brief    : Directed self-checking bench for spmv_mem_model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spmv_mem_model;

  localparam int LATENCY   = 16;
  localparam int DEPTH     = 65536;
  localparam int RSP_DEPTH = 32;
  localparam int ADDR_W    = 48;
  localparam int TAG_W     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_ld = 1'b0;
  logic              req_st = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [63:0]       req_d_or_tag = '0;
  logic              req_stall;
  logic              rsp_push;
  logic [TAG_W-1:0]  rsp_tag;
  logic [63:0]       rsp_q;
  logic              rsp_stall = 1'b0;
  logic [31:0]       ld_count;
  logic [31:0]       st_count;
  logic              err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spmv_mem_model #(
    .LATENCY(LATENCY), .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH),
    .ADDR_W(ADDR_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_ld(req_ld), .req_st(req_st),
    .req_addr(req_addr), .req_d_or_tag(req_d_or_tag), .req_stall(req_stall),
    .rsp_push(rsp_push), .rsp_tag(rsp_tag), .rsp_q(rsp_q), .rsp_stall(rsp_stall),
    .ld_count(ld_count), .st_count(st_count), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (rsp_push === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (rsp_push !== 1'b0 || rsp_tag !== '0 || rsp_q !== 64'd0 || req_stall !== 1'b0 ||
        ld_count !== 32'd0 || st_count !== 32'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: push=%b tag=%0d q=%h stall=%b ld=%0d st=%0d err=%b, required all 0",
               rsp_push, rsp_tag, rsp_q, req_stall, ld_count, st_count, err);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_latency();
    req_ld = 1'b1; req_addr = ADDR_W'(40); req_d_or_tag = 64'd3;
    step();
    req_ld = 1'b0;
    checks++;
    if (ld_count !== 32'd1) begin
      errors++; $display("FAIL ld_count_one: got %0d, required 1", ld_count);
    end
    for (int i = 1; i < LATENCY; i++) begin
      step();
      checks++;
      if (rsp_push !== 1'b0) begin
        errors++; $display("FAIL early_rsp: push=1 at edge N+%0d, required 0", i);
      end
    end
    step();
    checks++;
    if (rsp_push !== 1'b1 || rsp_tag !== 3'd3 || rsp_q !== 64'h1234) begin
      errors++;
      $display("FAIL load_latency: push=%b tag=%0d q=%h, required push=1 tag=3 q=1234", rsp_push, rsp_tag, rsp_q);
    end
    step();
    checks++;
    if (rsp_push !== 1'b0 || rsp_q !== 64'h1234) begin
      errors++; $display("FAIL rsp_hold: push=%b q=%h, required push=0 q=1234", rsp_push, rsp_q);
    end
  endtask

  task automatic test_store_load();
    bit seen;
    req_st = 1'b1; req_addr = ADDR_W'(80); req_d_or_tag = 64'hDEAD;
    step();
    req_st = 1'b0; req_ld = 1'b1; req_d_or_tag = 64'd1;
    step();
    req_ld = 1'b0;
    checks++;
    if (st_count !== 32'd1) begin
      errors++; $display("FAIL st_count_one: got %0d, required 1", st_count);
    end
    wait_rsp(3 * LATENCY, seen);
    checks++;
    if (!seen || rsp_q !== 64'hDEAD || rsp_tag !== 3'd1) begin
      errors++; $display("FAIL store_then_load: seen=%b q=%h tag=%0d, required seen=1 q=dead tag=1", seen, rsp_q, rsp_tag);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int r = 0;
    bit acc;
    for (int i = 0; i < 40; i++) dut.mem[100 + i] = 64'hA000 + 64'(i);
    rsp_stall = 1'b1;
    for (int c = 0; c < 40; c++) begin
      req_ld = 1'b1; req_addr = ADDR_W'((100 + k) * 8); req_d_or_tag = 64'(k % 8);
      acc = !req_stall;
      step();
      if (acc) k++;
    end
    req_ld = 1'b0;
    checks++;
    if (k !== RSP_DEPTH || req_stall !== 1'b1) begin
      errors++; $display("FAIL credit_stall: accepted=%0d stall=%b, required accepted=32 stall=1", k, req_stall);
    end
    checks++;
    if (rsp_push !== 1'b0) begin
      errors++; $display("FAIL stalled_push: push=%b, required 0", rsp_push);
    end
    rsp_stall = 1'b0;
    for (int c = 0; c < 200 && r < 40; c++) begin
      req_ld = (k < 40); req_addr = ADDR_W'((100 + k) * 8); req_d_or_tag = 64'(k % 8);
      acc = req_ld && !req_stall;
      step();
      if (acc) k++;
      if (rsp_push === 1'b1) begin
        checks++;
        if (rsp_q !== 64'hA000 + 64'(r) || rsp_tag !== TAG_W'(r % 8)) begin
          errors++;
          $display("FAIL order_rsp%0d: q=%h tag=%0d, required q=%h tag=%0d", r, rsp_q, rsp_tag, 64'hA000 + 64'(r), r % 8);
        end
        r++;
      end
    end
    req_ld = 1'b0;
    checks++;
    if (r !== 40 || k !== 40 || ld_count !== 32'd42) begin
      errors++; $display("FAIL drain_count: rsp=%0d acc=%0d ld=%0d, required 40 40 42", r, k, ld_count);
    end
  endtask

  task automatic test_errors();
    bit seen;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clean: got %b, required 0", err);
    end
    req_ld = 1'b1; req_addr = ADDR_W'(DEPTH * 8); req_d_or_tag = 64'd5;
    step();
    req_ld = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_oor_load: got %b, required 1", err);
    end
    wait_rsp(3 * LATENCY, seen);
    checks++;
    if (!seen || rsp_q !== 64'd0 || rsp_tag !== 3'd5) begin
      errors++; $display("FAIL oor_rsp: seen=%b q=%h tag=%0d, required seen=1 q=0 tag=5", seen, rsp_q, rsp_tag);
    end
    // Out-of-range store must not alias onto word 0.
    req_st = 1'b1; req_addr = ADDR_W'(DEPTH * 8); req_d_or_tag = 64'hBAD;
    step();
    req_st = 1'b0; req_ld = 1'b1; req_addr = '0; req_d_or_tag = 64'd2;
    step();
    req_ld = 1'b0;
    wait_rsp(3 * LATENCY, seen);
    checks++;
    if (!seen || rsp_q !== 64'h7777 || rsp_tag !== 3'd2) begin
      errors++; $display("FAIL oor_store_dropped: seen=%b q=%h tag=%0d, required seen=1 q=7777 tag=2", seen, rsp_q, rsp_tag);
    end
    pulse_reset();
    step();
    req_ld = 1'b1; req_st = 1'b1; req_addr = ADDR_W'(80); req_d_or_tag = 64'h0;
    step();
    req_ld = 1'b0; req_st = 1'b0;
    checks++;
    if (err !== 1'b1 || ld_count !== 32'd0 || st_count !== 32'd0) begin
      errors++; $display("FAIL both_req: err=%b ld=%0d st=%0d, required err=1 ld=0 st=0", err, ld_count, st_count);
    end
    req_ld = 1'b1; req_d_or_tag = 64'd6;
    step();
    req_ld = 1'b0;
    wait_rsp(3 * LATENCY, seen);
    checks++;
    if (!seen || rsp_q !== 64'hDEAD || rsp_tag !== 3'd6 || ld_count !== 32'd1) begin
      errors++; $display("FAIL both_req_no_store: seen=%b q=%h tag=%0d ld=%0d, required seen=1 q=dead tag=6 ld=1", seen, rsp_q, rsp_tag, ld_count);
    end
  endtask

  task automatic test_reset_midflight();
    int pushes = 0;
    bit seen;
    rsp_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_ld = 1'b1; req_addr = ADDR_W'(40); req_d_or_tag = 64'd4;
      step();
    end
    req_ld = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (ld_count !== 32'd11) begin
      errors++; $display("FAIL pre_reset_ld: got %0d, required 11", ld_count);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (rsp_push !== 1'b0 || rsp_tag !== '0 || rsp_q !== 64'd0 || req_stall !== 1'b0 ||
        ld_count !== 32'd0 || st_count !== 32'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: push=%b tag=%0d q=%h stall=%b ld=%0d st=%0d err=%b, required all 0",
               rsp_push, rsp_tag, rsp_q, req_stall, ld_count, st_count, err);
    end
    rst_n = 1'b1;
    rsp_stall = 1'b0;
    for (int i = 0; i < 2 * LATENCY; i++) begin
      step();
      if (rsp_push === 1'b1) pushes++;
    end
    checks++;
    if (pushes !== 0) begin
      errors++; $display("FAIL ghost_rsp: got %0d responses, required 0", pushes);
    end
    req_ld = 1'b1; req_addr = ADDR_W'(40); req_d_or_tag = 64'd7;
    step();
    req_ld = 1'b0;
    wait_rsp(3 * LATENCY, seen);
    checks++;
    if (!seen || rsp_q !== 64'h1234 || rsp_tag !== 3'd7) begin
      errors++; $display("FAIL post_reset_load: seen=%b q=%h tag=%0d, required seen=1 q=1234 tag=7", seen, rsp_q, rsp_tag);
    end
  endtask

`ifdef SPMV_MEM_STALL_INJECT_EN
  task automatic test_stall_inject();
    int sent = 0;
    int got = 0;
    int stall_cycles = 0;
    int drive_cycles = 0;
    bit acc;
    logic [63:0] exp_q[$];
    logic [63:0] exp_d;
    for (int i = 0; i < 64; i++) dut.mem[200 + i] = 64'hC0DE0000 + 64'(i);
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      acc = 1'b0;
      if (sent < 1000) begin
        req_ld = 1'b1; req_addr = ADDR_W'((200 + sent % 64) * 8); req_d_or_tag = 64'(sent % 8);
        drive_cycles++;
        if (req_stall) stall_cycles++;
        acc = !req_stall;
      end else begin
        req_ld = 1'b0;
      end
      step();
      if (acc) begin
        exp_q.push_back(64'hC0DE0000 + 64'(sent % 64));
        sent++;
      end
      if (rsp_push === 1'b1) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        checks++;
        if (rsp_q !== exp_d) begin
          errors++; $display("FAIL inject_rsp%0d: q=%h, required %h", got, rsp_q, exp_d);
        end
        got++;
      end
    end
    req_ld = 1'b0;
    checks++;
    if (got !== 1000) begin
      errors++; $display("FAIL inject_count: got %0d responses, required 1000", got);
    end
    checks++;
    if (stall_cycles * 100 < drive_cycles * 20 || stall_cycles * 100 > drive_cycles * 30) begin
      errors++; $display("FAIL inject_duty: stalls=%0d of %0d cycles, required 20%%..30%%", stall_cycles, drive_cycles);
    end
  endtask
`endif

  initial begin
    dut.mem[0] = 64'h7777;
    dut.mem[5] = 64'h1234;
    test_reset();
`ifdef SPMV_MEM_STALL_INJECT_EN
    test_stall_inject();
`else
    test_load_latency();
    test_store_load();
    test_back_to_back();
    test_errors();
    test_reset_midflight();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
